// File: rtl/prime_trial_divider.sv
// Iterative primality tester: trial division by 2 and odd divisors, each
// remainder produced by a bit-serial restoring shift-subtract unit.
module prime_trial_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    output logic             result,
    output logic             done,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned SQ_W  = 2 * WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_DIV,
        S_EVAL,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   v_q, v_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               result_q, result_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic [SQ_W-1:0]    d_sq_c;
    logic [WIDTH:0]     t_c;

    // Double-width square so the d*d > v test can never wrap
    assign d_sq_c = SQ_W'(d_q) * SQ_W'(d_q);
    assign t_c    = {rem_q[WIDTH-1:0], shreg_q[WIDTH-1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            v_q      <= '0;
            d_q      <= '0;
            rem_q    <= '0;
            shreg_q  <= '0;
            cnt_q    <= '0;
            result_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            v_q      <= v_d;
            d_q      <= d_d;
            rem_q    <= rem_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        v_d      = v_q;
        d_d      = d_q;
        rem_d    = rem_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = done_q;
        busy_d   = busy_q;

        unique case (state_q)
            S_IDLE: begin
                done_d = 1'b0;
                if (start) begin
                    v_d     = value;
                    d_d     = WIDTH'(2);
                    busy_d  = 1'b1;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!start) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (v_q < WIDTH'(2)) begin
                    result_d = 1'b0;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = S_DONE;
                end else if (d_sq_c > SQ_W'(v_q)) begin
                    result_d = 1'b1;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = S_DONE;
                end else begin
                    rem_d   = '0;
                    shreg_d = v_q;
                    cnt_d   = CNT_W'(WIDTH);
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                if (!start) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    rem_d   = (t_c >= {1'b0, d_q}) ? (t_c - {1'b0, d_q}) : t_c;
                    shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                    cnt_d   = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_EVAL;
                    end
                end
            end
            S_EVAL: begin
                if (!start) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (rem_q == '0) begin
                    result_d = 1'b0;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = S_DONE;
                end else begin
                    // Only odd divisors after 2
                    d_d     = (d_q == WIDTH'(2)) ? WIDTH'(3) : (d_q + WIDTH'(2));
                    state_d = S_CHECK;
                end
            end
            S_DONE: begin
                done_d = 1'b1;
                busy_d = 1'b0;
                if (!start) begin
                    done_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign result = result_q;
    assign done   = done_q;
    assign busy   = busy_q;

endmodule
